// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall sequencing logic of the
// 5-stage core: controller states, front-end control bundle, common constants.
package hazard_stall_controller_pkg;

    localparam int REG_W             = 5;
    localparam int DEFAULT_MD_CYCLES = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
    } fe_ctrl_t;

    localparam fe_ctrl_t FE_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam fe_ctrl_t FE_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam fe_ctrl_t FE_FLUSH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam fe_ctrl_t FE_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/hazard_stall_controller_md_countdown.sv
// Loadable down-counter with zero flag, used to time multi-cycle unit occupancy.
module md_countdown #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Front-end sequencing for load-use, taken-branch, mult/div occupancy and halt;
// drives PC/IF-ID enables and flushes and counts stalled front-end cycles.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MD_CYCLES = DEFAULT_MD_CYCLES,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] r1,
    input  logic [REG_W-1:0] r2,
    input  logic             r1_used,
    input  logic             r2_used,
    input  logic             id_md,
    input  logic             id_halt,
    input  logic [REG_W-1:0] exwaddr,
    input  logic             exrw,
    input  logic             exmtr,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = $clog2(MD_CYCLES) + 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_CYCLES - 1);

    state_t   state, next_state;
    fe_ctrl_t ctrl;
    logic     lu;
    logic     cnt_clear, cnt_load, cnt_dec, md_zero;

    assign lu = exrw && exmtr && (exwaddr != '0) &&
                ((r1_used && r1 == exwaddr) || (r2_used && r2 == exwaddr));

    // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
    always_comb begin
        ctrl       = FE_RUN;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        if (!rst_n) begin
            ctrl       = FE_RESET;
            next_state = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    // A taken branch makes the ID instruction wrong-path, so its hazards are moot.
                    if (branch_taken) begin
                        ctrl = FE_FLUSH;
                    end else if (lu) begin
                        ctrl = FE_STALL;
                    end else if (id_md) begin
                        ctrl       = FE_STALL;
                        md_start   = 1'b1;
                        cnt_load   = 1'b1;
                        next_state = MD_WAIT;
                    end else if (id_halt) begin
                        ctrl       = FE_STALL;
                        next_state = HALT;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (branch_taken) begin
                        ctrl       = FE_FLUSH;
                        cnt_clear  = 1'b1;
                        next_state = RUN;
                    end else if (!md_zero) begin
                        ctrl    = FE_STALL;
                        cnt_dec = 1'b1;
                    end else begin
                        next_state = RUN;
                    end
                end
                HALT: begin
                    ctrl = FE_STALL;
                end
                default: begin
                    ctrl       = FE_STALL;
                    next_state = RUN;
                end
            endcase
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;

    md_countdown #(.W(MD_W)) u_md_countdown (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (MD_LOAD),
        .dec      (cnt_dec),
        .zero     (md_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            // Halted cycles are not stalls worth counting; the entry cycle still is.
            if (state != HALT && !ctrl.pc_en && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller (MD_CYCLES=4 and 1, CNT_W=4).
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] r1, r2, exwaddr;
    logic       r1_used, r2_used, id_md, id_halt, exrw, exmtr, branch_taken;

    logic       pc_en, ifid_en, ifid_flush, idex_flush, md_start, md_busy;
    logic [3:0] stall_cnt;
    logic       b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_md_start, b_md_busy;
    logic [3:0] b_stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MD_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .r1(r1), .r2(r2), .r1_used(r1_used), .r2_used(r2_used),
        .id_md(id_md), .id_halt(id_halt), .exwaddr(exwaddr), .exrw(exrw), .exmtr(exmtr),
        .branch_taken(branch_taken), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_stall_controller #(.MD_CYCLES(1), .CNT_W(4)) dut_md1 (
        .clk(clk), .rst_n(rst_n), .r1(r1), .r2(r2), .r1_used(r1_used), .r2_used(r2_used),
        .id_md(id_md), .id_halt(id_halt), .exwaddr(exwaddr), .exrw(exrw), .exmtr(exmtr),
        .branch_taken(branch_taken), .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .md_start(b_md_start), .md_busy(b_md_busy), .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet();
        r1 = '0; r2 = '0; exwaddr = '0;
        r1_used = 0; r2_used = 0; id_md = 0; id_halt = 0;
        exrw = 0; exmtr = 0; branch_taken = 0;
    endtask

    // Advance to the next cycle's input-drive point.
    task automatic next();
        @(negedge clk);
    endtask

    task automatic set_lu(input logic [4:0] reg_idx);
        exrw = 1; exmtr = 1; exwaddr = reg_idx; r1 = reg_idx; r1_used = 1;
    endtask

    task automatic do_reset();
        next();
        rst_n = 0;
        quiet();
        next();
        rst_n = 1;
    endtask

    task automatic chk_stall(input string tag);
        check({tag, "_pc_en"},      pc_en,      0);
        check({tag, "_ifid_en"},    ifid_en,    0);
        check({tag, "_ifid_flush"}, ifid_flush, 0);
        check({tag, "_idex_flush"}, idex_flush, 1);
    endtask

    task automatic chk_run(input string tag);
        check({tag, "_pc_en"},      pc_en,      1);
        check({tag, "_ifid_en"},    ifid_en,    1);
        check({tag, "_ifid_flush"}, ifid_flush, 0);
        check({tag, "_idex_flush"}, idex_flush, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_pc_en"},      pc_en,      0);
        check({tag, "_ifid_en"},    ifid_en,    0);
        check({tag, "_ifid_flush"}, ifid_flush, 1);
        check({tag, "_idex_flush"}, idex_flush, 1);
        check({tag, "_md_start"},   md_start,   0);
        check({tag, "_md_busy"},    md_busy,    0);
        check({tag, "_stall_cnt"},  stall_cnt,  0);
    endtask

    initial begin
        rst_n = 0;
        quiet();
        #2;
        chk_reset_outs("reset");
        next();
        rst_n = 1;

        // Load-use on r1, then the same pattern aimed at register 0.
        next(); set_lu(5'd8); #1;
        chk_stall("lu");
        next(); set_lu(5'd0); #1;
        chk_run("lu_r0");
        check("lu_cnt", stall_cnt, 1);
        next(); quiet(); exrw = 1; exmtr = 1; exwaddr = 5'd9; r2 = 5'd9; r2_used = 1; #1;
        chk_stall("lu_r2");
        next(); quiet(); #1;
        chk_run("lu_after");
        check("lu_r2_cnt", stall_cnt, 2);

        // Branch taken over a pending load-use.
        next(); set_lu(5'd8); branch_taken = 1; #1;
        check("br_pc_en", pc_en, 1);
        check("br_ifid_en", ifid_en, 1);
        check("br_ifid_flush", ifid_flush, 1);
        check("br_idex_flush", idex_flush, 1);
        next(); quiet(); #1;
        check("br_cnt", stall_cnt, 2);

        // Mult/div with id_md held through the release cycle.
        next(); id_md = 1; #1;
        chk_stall("md1");
        check("md1_start", md_start, 1);
        check("md1_busy", md_busy, 0);
        for (int c = 2; c <= 4; c++) begin
            next(); #1;
            check($sformatf("md%0d_pc_en", c), pc_en, 0);
            check($sformatf("md%0d_start", c), md_start, 0);
            check($sformatf("md%0d_busy", c), md_busy, 1);
        end
        next(); #1;
        chk_run("md5");
        check("md5_busy", md_busy, 1);
        check("md5_start", md_start, 0);
        next(); id_md = 0; #1;
        chk_run("md6");
        check("md6_busy", md_busy, 0);
        check("md6_cnt", stall_cnt, 6);

        // Branch taken aborts an in-flight mult/div.
        next(); id_md = 1; #1;
        check("mdbr1_start", md_start, 1);
        next(); id_md = 0; branch_taken = 1; #1;
        check("mdbr2_busy", md_busy, 1);
        check("mdbr2_ifid_flush", ifid_flush, 1);
        check("mdbr2_pc_en", pc_en, 1);
        next(); quiet(); #1;
        check("mdbr3_busy", md_busy, 0);
        chk_run("mdbr3");
        check("mdbr3_cnt", stall_cnt, 7);

        // Reset asserted during the second MD_WAIT cycle.
        do_reset();
        next(); id_md = 1; #1;
        check("rmd1_start", md_start, 1);
        next(); id_md = 0; #1;
        check("rmd2_busy", md_busy, 1);
        next(); #1;
        check("rmd3_busy", md_busy, 1);
        #1 rst_n = 0;
        #1;
        chk_reset_outs("rmd_async");
        next(); rst_n = 1; #1;
        chk_run("rmd_rel");
        check("rmd_rel_busy", md_busy, 0);
        next(); #1;
        chk_run("rmd_rel2");
        check("rmd_rel2_start", md_start, 0);
        check("rmd_rel2_cnt", stall_cnt, 0);

        // Halt is sticky and ignores branches.
        next(); id_halt = 1; #1;
        chk_stall("halt1");
        next(); id_halt = 0; #1;
        chk_stall("halt2");
        check("halt2_cnt", stall_cnt, 1);
        next(); branch_taken = 1; #1;
        chk_stall("halt_br");
        next(); quiet(); #1;
        check("halt4_pc_en", pc_en, 0);
        next(); #1;
        check("halt5_cnt", stall_cnt, 1);

        // MD_CYCLES=1 instance: release on first MD_WAIT cycle, no relaunch.
        do_reset();
        next(); id_md = 1; #1;
        check("md1c1_start", b_md_start, 1);
        check("md1c1_pc_en", b_pc_en, 0);
        next(); #1;
        check("md1c2_busy", b_md_busy, 1);
        check("md1c2_pc_en", b_pc_en, 1);
        check("md1c2_start", b_md_start, 0);
        next(); id_md = 0; #1;
        check("md1c3_busy", b_md_busy, 0);
        check("md1c3_cnt", b_stall_cnt, 1);

        // Counter saturation with 20 back-to-back load-use cycles.
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            next(); set_lu(5'd3); #1;
            if (c == 16) check("sat_15", stall_cnt, 15);
        end
        next(); quiet(); #1;
        check("sat_hold", stall_cnt, 15);
        check("sat_run", pc_en, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage core. It sits beside the ID-stage forwarding logic.
- Resolves the hazards forwarding cannot cover:
  - load-use: 1-cycle stall plus bubble
  - taken-branch: IF/ID and ID/EX flush
  - multi-cycle mult/div occupancy: FSM-timed stall
  - halt: sticky freeze
- Drives PC/IF-ID enables and flushes, and keeps a saturating stall-cycle counter.

Parameters:
MD_CYCLES, 32, cycles the mult/div unit stalls the front end per operation (must be >= 1)
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
r1  input  5  ID-stage source register 1 (rs)
r2  input  5  ID-stage source register 2 (rt)
r1_used  input  1  ID instruction reads r1
r2_used  input  1  ID instruction reads r2
id_md  input  1  ID instruction is mult/div
id_halt  input  1  ID instruction is halt/syscall-stop
exwaddr  input  5  EX-stage destination register
exrw  input  1  EX-stage writes the register file
exmtr  input  1  EX-stage instruction is a load (mem-to-reg)
branch_taken  input  1  EX-stage branch/jump resolved taken
pc_en  output  1  PC update enable
ifid_en  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to NOP
idex_flush  output  1  insert bubble into ID/EX
md_start  output  1  one-cycle launch pulse to the mult/div unit
md_busy  output  1  mult/div operation in progress
stall_cnt  output  CNT_W  saturating count of front-end stall cycles

Behaviour:
- State is registered: state {RUN, MD_WAIT, HALT}, md_cnt (ceil(log2(MD_CYCLES))+1 bits), stall_cnt. Outputs are combinational from state and inputs.
- Reset (rst_n=0, asynchronous):
  - state=RUN, md_cnt=0, stall_cnt=0.
  - Outputs forced: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, md_start=0, md_busy=0.
- Hazard term: lu = exrw & exmtr & (exwaddr!=0) & ((r1_used & r1==exwaddr) | (r2_used & r2==exwaddr)).
- "Stall" means pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0. "Run" means pc_en=1, ifid_en=1, both flushes 0.
- RUN, first match wins:
  1. branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Stay in RUN. Pending lu/id_md/id_halt are ignored because the ID instruction is wrong-path.
  2. lu: stall for exactly this cycle; stay in RUN. Next cycle the load is in MEM and forwarding covers it.
  3. id_md: stall, md_start=1, md_cnt<=MD_CYCLES-1, go to MD_WAIT.
  4. id_halt: stall, go to HALT.
  5. Otherwise: run.
- MD_WAIT: md_busy=1.
  - branch_taken: flush as in RUN, md_cnt<=0, go to RUN, md_busy drops the next cycle.
  - Else if md_cnt!=0: stall, md_cnt<=md_cnt-1.
  - Else (md_cnt==0): run for the release cycle, go to RUN. id_md still high in this cycle must not relaunch.
  - Total stalled cycles per mult/div is exactly MD_CYCLES. With MD_CYCLES=1 the release happens on the first MD_WAIT cycle.
- HALT: stall every cycle. Held until rst_n; branch_taken is ignored.
- stall_cnt:
  - Increments on each cycle with rst_n=1, state!=HALT, pc_en=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - Branch flush cycles do not count.
- Reset asserted mid-MD_WAIT or in HALT: immediate return to RUN state values. md_start is never re-issued for the aborted operation.
- No combinational path from stall_cnt or md_cnt to the inputs.

Decomposition:
- Shared pipeline package holds:
  - state enum {RUN, MD_WAIT, HALT}
  - register-index width (5)
  - the NOP encoding used by flushes
  - default MD_CYCLES
- One natural sub-module: md_countdown. It provides load, decrement, and zero flag for md_cnt, and is reused by any future multi-cycle unit.

Test Plan:
1. Load-use: exrw=1, exmtr=1, exwaddr=8, r1=8, r1_used=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1 for that cycle only; stall_cnt=1. Repeat with exwaddr=0, r1=0 → no stall.
2. Branch over hazard: same lu condition plus branch_taken=1 → pc_en=1, ifid_flush=1, idex_flush=1; stall_cnt unchanged.
3. Mult/div, MD_CYCLES=4: id_md=1 held → md_start pulses once; pc_en=0 for exactly 4 cycles; md_busy=1 for cycles 2-5; run on cycle 5; no second md_start; stall_cnt=4.
4. Reset mid mult/div: rst_n low during the 2nd MD_WAIT cycle → md_busy=0 and forced reset outputs immediately. After release, state is RUN and pc_en=1 with quiet inputs.
5. Halt: id_halt=1 → pc_en=0 on every following cycle, including with branch_taken=1. stall_cnt stops incrementing after the entry cycle (value 1).
6. Saturation, CNT_W=4: 20 consecutive lu cycles → stall_cnt reaches 15 and holds.
